// File: rtl/unified_sram_arbiter_pkg.sv
// Shared definitions for the unified SRAM arbiter: owner encoding, default
// fetch starvation limit and SRAM data width.
package unified_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int SRAM_DW        = 32;

endpackage

// File: rtl/unified_sram_arbiter_pick.sv
// Grant select for the shared SRAM: data port wins by default, fetch is forced
// through once it has lost STARVE_MAX consecutive cycles.
module sram_arb_pick
  import unified_sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inst_req,
  input  logic i_data_req,
  output logic o_grant_inst,
  output logic o_grant_data
);

  localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_force_inst;

  always_comb begin
    w_force_inst = i_inst_req && (r_starve_cnt == LP_MAX);
    o_grant_inst = 1'b0;
    o_grant_data = 1'b0;
    // Grants are held off for as long as reset is asserted.
    if (!rst) begin
      if (w_force_inst) begin
        o_grant_inst = 1'b1;
      end else if (i_data_req) begin
        o_grant_data = 1'b1;
      end else if (i_inst_req) begin
        o_grant_inst = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (i_inst_req && !o_grant_inst) begin
      if (r_starve_cnt != LP_MAX) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/unified_sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and
// load/store; read data returns one cycle after the grant.
module unified_sram_arbiter
  import unified_sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic [AW-1:0]      inst_addr,
  input  logic               inst_cancel,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [SRAM_DW-1:0] inst_rdata,
  input  logic               data_req,
  input  logic [3:0]         data_we,
  input  logic [AW-1:0]      data_addr,
  input  logic [SRAM_DW-1:0] data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [SRAM_DW-1:0] data_rdata,
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [AW-1:0]      sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata
);

  logic          w_grant_inst;
  logic          w_grant_data;
  owner_t        r_owner;
  owner_t        w_owner_nxt;
  logic [AW-1:0] r_addr_hold;

  sram_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk          (clk),
    .rst          (rst),
    .i_inst_req   (inst_req),
    .i_data_req   (data_req),
    .o_grant_inst (w_grant_inst),
    .o_grant_data (w_grant_data)
  );

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  always_comb begin
    sram_en    = w_grant_inst | w_grant_data;
    sram_we    = 4'd0;
    sram_wdata = '0;
    sram_addr  = r_addr_hold;
    if (w_grant_data) begin
      sram_we    = data_we;
      sram_wdata = data_wdata;
      sram_addr  = data_addr;
    end else if (w_grant_inst) begin
      sram_addr  = inst_addr;
    end
  end

  // Idle cycles keep the previous address on the SRAM bus to avoid toggling.
  always_ff @(posedge clk) begin
    if (sram_en) begin
      r_addr_hold <= sram_addr;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_grant_data) begin
      w_owner_nxt = OWN_DATA;
    end else if (w_grant_inst && !inst_cancel) begin
      w_owner_nxt = OWN_INST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // A redirect in the response cycle still drops the stale fetch data.
  assign inst_data_ok = (r_owner == OWN_INST) && !inst_cancel;
  assign data_data_ok = (r_owner == OWN_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: doc/unified_sram_arbiter.md
Name: unified_sram_arbiter

Overview:
- Shares one single-port synchronous SRAM between two requesters: instruction fetch (IF stage) and load/store (EXE stage issue, MEM stage response).
- This lets the pipelined CPU run against a unified memory instead of separate inst/data SRAMs.
- Accepts at most one request per cycle. The read response returns exactly one cycle after the grant.
- Data port has priority, with a starvation guard for fetch. A fetch-cancel input drops a stale fetch response after a branch redirect.

Parameters:
- STARVE_MAX, 4: number of consecutive cycles a pending inst_req may lose arbitration before it is forced to win. Legal range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- inst_req  in  1  fetch request valid.
- inst_addr  in  AW  fetch address.
- inst_cancel  in  1  branch redirect; discard any fetch response due this cycle or next.
- inst_addr_ok  out  1  fetch request granted this cycle (combinational).
- inst_data_ok  out  1  fetch read data valid (registered).
- inst_rdata  out  32  fetch read data; meaningful only when inst_data_ok=1.
- data_req  in  1  load/store request valid.
- data_we  in  4  byte write enables; 0 means load.
- data_addr  in  AW  load/store address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  load/store granted this cycle (combinational).
- data_data_ok  out  1  load data valid or store complete (registered).
- data_rdata  out  32  load data; meaningful only when data_data_ok=1.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  AW  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en.

Behaviour:
- Reset (async, rst=1):
  - owner register = NONE, starve_cnt = 0.
  - inst_data_ok = 0 and data_data_ok = 0 immediately.
  - While rst=1 the grant logic is forced off: sram_en = 0, sram_we = 0, both addr_ok = 0.
  - A response in flight when rst asserts is lost, never delivered.
- Grant, combinational and evaluated every cycle:
  - force_inst = inst_req & (starve_cnt == STARVE_MAX).
  - If force_inst: grant inst.
  - Else if data_req: grant data.
  - Else if inst_req: grant inst.
  - Otherwise no grant.
  - At most one of inst_addr_ok / data_addr_ok is high in a cycle.
- SRAM drive:
  - sram_en = any grant.
  - On a data grant: sram_addr/sram_we/sram_wdata come from the data port.
  - On an inst grant: sram_addr = inst_addr, sram_we = 0, sram_wdata = 0.
  - With no grant: sram_we = 0 and sram_addr holds its last value (don't care).
- Owner register, updated each edge:
  - Becomes INST, DATA or NONE according to this cycle's grant.
  - Exception: an inst grant in a cycle with inst_cancel=1 records NONE.
- Responses:
  - inst_data_ok is high in cycle t+1 when owner=INST and inst_cancel=0 in cycle t+1.
  - data_data_ok is high in cycle t+1 when owner=DATA.
  - inst_rdata and data_rdata are wired directly to sram_rdata.
  - Stores assert data_data_ok like loads, one cycle after grant.
- Latency: grant to data_ok is exactly 1 cycle. Throughput is 1 grant per cycle; back-to-back grants to either port are legal.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle that inst_req=1 and inst is not granted.
  - Clears to 0 on an inst grant or when inst_req=0.
- Simultaneous events:
  - inst_cancel in the grant cycle: the grant still occurs (the SRAM read is harmless) but no response is delivered.
  - inst_cancel in the response cycle: inst_data_ok is suppressed.
  - New grant in the same cycle a response returns: legal, no conflict.
- Requesters must accept data_ok unconditionally; there is no response backpressure.
- Requesters must hold req/addr/wdata stable until addr_ok. The arbiter does not latch request fields.

Decomposition:
- Shared package holds:
  - owner encoding OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2;
  - default STARVE_MAX;
  - SRAM data width constant 32.
- One sub-module, sram_arb_pick: the combinational grant select plus the starve_cnt register. The owner/response logic stays in the top of the block.

Test Plan:
- Reset mid-response: assert rst the cycle after a load grant → data_data_ok=0 immediately; after release, both ok outputs stay 0 and starve_cnt=0.
- Load alone: data_req=1, data_we=0, data_addr=0x1000, SRAM holds 0xDEADBEEF → data_addr_ok=1 in cycle 0; data_data_ok=1 and data_rdata=0xDEADBEEF in cycle 1; inst_data_ok=0 throughout.
- Store: data_we=4'b0011, data_addr=0x2004, data_wdata=0x12345678 → sram_we=0011 and sram_addr=0x2004 in the grant cycle; data_data_ok=1 next cycle. A following fetch of 0x2004 returns the low half updated.
- Conflict and starvation with STARVE_MAX=4:
  - inst_req and data_req both held high for 10 cycles → grants D,D,D,D,I,D,D,D,D,I.
  - inst_data_ok follows each I grant by exactly 1 cycle.
- Cancel, two cases:
  - inst grant at 0x1c000000 with inst_cancel=1 in the grant cycle → no inst_data_ok next cycle.
  - Repeat with inst_cancel=1 only in the response cycle → inst_data_ok stays 0.
- Back-to-back: alternating inst 0x0, data load 0x100, inst 0x4 in consecutive cycles → ok pulses alternate inst/data/inst one cycle later, each with the correct rdata.
